// File: rtl/cpu_pkg.sv
// Shared CPU definitions: 4-bit opcode constants and the fetch FSM state encoding.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_LOAD  = 4'h1,
    OP_STORE = 4'h2,
    OP_SET   = 4'h3,
    OP_ADD   = 4'h4,
    OP_SUB   = 4'h5,
    OP_BEQ   = 4'h6,
    OP_BNEQ  = 4'h7,
    OP_AND   = 4'h8,
    OP_OR    = 4'h9,
    OP_XOR   = 4'hA
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc, inst} pairs; head entry is read straight from the storage registers.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [W-1:0]               i_wdata,
  output logic [W-1:0]               o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC register driving a combinational ROM, feeding a small prefetch queue.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int INST_W = 16,
  parameter int QDEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [INST_W-1:0]       rom_inst,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [INST_W-1:0]       out_inst,
  output logic [ADDR_W-1:0]       out_pc,
  input  logic                    redir_valid,
  input  logic [ADDR_W-1:0]       redir_pc,
  output logic [1:0]              dbg_state,
  output logic [$clog2(QDEPTH):0] dbg_count
);

  fetch_state_e             r_state;
  fetch_state_e             w_next_state;
  logic [ADDR_W-1:0]        r_pc;
  logic [ADDR_W-1:0]        w_next_pc;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_flush;
  logic                     w_full;
  logic                     w_empty;
  logic [ADDR_W+INST_W-1:0] w_rdata;

  // Handshake: the head entry transfers exactly on a cycle with out_valid=1 and
  // out_ready=1; while out_ready=0 the head stays put and out_* remain stable.
  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
    end
  end

  // A redirect wins over everything, including a pending redirect in FLUSH.
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_push       = 1'b0;
    w_flush      = 1'b0;
    if (redir_valid) begin
      w_flush      = 1'b1;
      w_next_pc    = redir_pc;
      w_next_state = ST_FLUSH;
    end else begin
      case (r_state)
        ST_IDLE:  w_next_state = ST_RUN;
        ST_FLUSH: w_next_state = ST_RUN;
        ST_RUN: begin
          if (!w_full || w_pop) begin
            w_push    = 1'b1;
            w_next_pc = r_pc + ADDR_W'(1);
          end
        end
        default:  w_next_state = ST_IDLE;
      endcase
    end
  end

  fetch_queue #(
    .DEPTH (QDEPTH),
    .W     (ADDR_W + INST_W)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_wdata ({r_pc, rom_inst}),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (dbg_count)
  );

  assign rom_addr  = r_pc;
  assign out_pc    = w_rdata[ADDR_W+INST_W-1:INST_W];
  assign out_inst  = w_rdata[INST_W-1:0];
  assign dbg_state = r_state;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: queue-based reference model checked every cycle, plus directed scenarios.
module tb_inst_fetch;

  localparam int AW = 8;
  localparam int IW = 16;
  localparam int QD = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [AW-1:0]     rom_addr;
  logic [IW-1:0]     rom_inst;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [IW-1:0]     out_inst;
  logic [AW-1:0]     out_pc;
  logic              redir_valid = 1'b0;
  logic [AW-1:0]     redir_pc = '0;
  logic [1:0]        dbg_state;
  logic [$clog2(QD):0] dbg_count;

  logic [IW-1:0]     rom [256];

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  inst_fetch #(.ADDR_W(AW), .INST_W(IW), .QDEPTH(QD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rom_addr    (rom_addr),
    .rom_inst    (rom_inst),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .dbg_state   (dbg_state),
    .dbg_count   (dbg_count)
  );

  assign rom_inst = rom[rom_addr];

  // ---------------- reference model ----------------
  // Queue of expected {pc, inst}; one idle cycle after reset or redirect, then
  // fetch whenever there is room after this cycle's pop.
  logic [AW+IW-1:0] exp_q[$];
  int m_pc   = 0;
  int m_hold = 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_pc   = 0;
      m_hold = 1;
    end else if (redir_valid) begin
      exp_q.delete();
      m_pc   = int'(redir_pc);
      m_hold = 1;
    end else begin
      if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
      if (m_hold > 0) m_hold--;
      else if (exp_q.size() < QD) begin
        exp_q.push_back({AW'(m_pc), rom[m_pc]});
        m_pc = (m_pc + 1) % 256;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_rom_addr", 32'(rom_addr), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_pc", 32'(out_pc), 0);
      check("rst_out_inst", 32'(out_inst), 0);
    end else begin
      check("model_out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("model_rom_addr", 32'(rom_addr), 32'(m_pc));
      check("model_occupancy", 32'(dbg_count), 32'(exp_q.size()));
      if (exp_q.size() != 0) begin
        check("model_out_pc", 32'(out_pc), 32'(exp_q[0][AW+IW-1:IW]));
        check("model_out_inst", 32'(out_inst), 32'(exp_q[0][IW-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!out_valid && k < 8) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(out_valid), 1);
  endtask

  task automatic redirect(input logic [AW-1:0] pc);
    redir_valid = 1'b1;
    redir_pc    = pc;
    step(1);
    redir_valid = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) rom[i] = {8'hC5 ^ 8'(i), 8'(i)};
    rom[0]   = 16'h32FF;
    rom[1]   = 16'h3180;
    rom[2]   = 16'h2210;
    rom[3]   = 16'h3000;
    rom[6]   = 16'h0000;
    rom[255] = 16'h7E55;

    step(3);
    rst_n = 1'b1;

    // Streaming start: pc 0..3 back to back
    step(2);
    check("start_valid", 32'(out_valid), 1);
    check("start_pc0", 32'(out_pc), 0);
    check("start_inst0", 32'(out_inst), 32'h32FF);
    step(1);
    check("start_pc1", 32'(out_pc), 1);
    check("start_inst1", 32'(out_inst), 32'h3180);
    step(1);
    check("start_pc2", 32'(out_pc), 2);
    step(1);
    check("start_pc3", 32'(out_pc), 3);
    check("start_inst3", 32'(out_inst), 32'h3000);

    // Redirect to 0 while pc 3 is at the head
    redirect(8'd0);
    check("redir0_flush_valid", 32'(out_valid), 0);
    wait_valid("redir0_refetch_timeout");
    check("redir0_pc", 32'(out_pc), 0);
    check("redir0_inst", 32'(out_inst), 32'h32FF);

    // PC wrap 255 -> 0 -> 1
    step(2);
    redirect(8'd255);
    wait_valid("wrap_timeout");
    check("wrap_pc255", 32'(out_pc), 255);
    check("wrap_inst255", 32'(out_inst), 32'h7E55);
    step(1);
    check("wrap_pc0", 32'(out_pc), 0);
    step(1);
    check("wrap_pc1", 32'(out_pc), 1);

    // Back-to-back redirects: the later one wins
    redir_valid = 1'b1;
    redir_pc    = 8'd5;
    step(1);
    redir_pc    = 8'd9;
    step(1);
    redir_valid = 1'b0;
    wait_valid("double_redir_timeout");
    check("double_redir_pc", 32'(out_pc), 9);

    // NOP is queued like any other instruction
    redirect(8'd4);
    wait_valid("nop_timeout");
    check("nop_pc4", 32'(out_pc), 4);
    step(2);
    check("nop_pc6", 32'(out_pc), 6);
    check("nop_inst", 32'(out_inst), 0);

    // Irregular backpressure pattern, checked by the model
    for (int i = 0; i < 24; i++) begin
      out_ready = ((i % 3) != 1) && ((i % 7) != 4);
      step(1);
    end
    out_ready = 1'b1;
    step(2);

    // Restart with out_ready low: queue fills and fetch PC freezes
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(7);
    check("fill_occupancy", 32'(dbg_count), QD);
    check("fill_rom_addr", 32'(rom_addr), QD);
    check("fill_out_inst", 32'(out_inst), 32'h32FF);
    check("fill_out_pc", 32'(out_pc), 0);

    // Push and pop together at full keep occupancy at QDEPTH
    out_ready = 1'b1;
    step(3);
    check("full_pushpop_occupancy", 32'(dbg_count), QD);
    out_ready = 1'b0;
    step(3);

    // Asynchronous reset with a full queue
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 0);
    check("async_rst_occupancy", 32'(dbg_count), 0);
    check("async_rst_rom_addr", 32'(rom_addr), 0);
    step(2);
    out_ready = 1'b1;
    rst_n = 1'b1;
    wait_valid("restart_timeout");
    check("restart_pc", 32'(out_pc), 0);
    check("restart_inst", 32'(out_inst), 32'h32FF);
    step(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
